// File: rtl/axi_b_resp_gen.sv
// axi_b_resp_gen: in-order AW tag FIFO, APB error accumulation and AXI B beat generation
module axi_b_resp_gen #(
  parameter int ID_WIDTH     = 4,
  parameter int USER_WIDTH   = 1,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               aw_push_i,
  input  logic [ID_WIDTH-1:0]                aw_id_i,
  input  logic [USER_WIDTH-1:0]              aw_user_i,
  output logic                               aw_ready_o,
  input  logic                               wr_done_i,
  input  logic                               wr_err_i,
  input  logic                               wr_last_i,
  output logic                               done_ready_o,
  output logic                               master_valid_o,
  output logic [1:0]                         master_resp_o,
  output logic [ID_WIDTH-1:0]                master_id_o,
  output logic [USER_WIDTH-1:0]              master_user_o,
  input  logic                               master_ready_i,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]  outstanding_o,
  output logic                               proto_err_o
);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int PW = BUFFER_DEPTH > 1 ? $clog2(BUFFER_DEPTH) : 1;
  localparam int TW = ID_WIDTH + USER_WIDTH;
  typedef enum logic {IDLE, VALID} state_t;
  state_t state, state_next;
  logic [TW-1:0] mem [BUFFER_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] head;
  logic err_acc, push, accept, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(BUFFER_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign aw_ready_o     = count < CW'(BUFFER_DEPTH);
  assign done_ready_o   = (count != '0) && (!wr_last_i || !master_valid_o || master_ready_i);
  assign push           = aw_push_i && aw_ready_o;
  assign accept         = wr_done_i && done_ready_o;
  assign pop            = accept && wr_last_i;
  assign head           = mem[rd_ptr];
  assign outstanding_o  = count;
  assign master_valid_o = state == VALID;
  // Tag storage; slots are only read once written, so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {aw_id_i, aw_user_i};
  end
  // FIFO pointers and occupancy; a same-cycle push and pop leave the count unchanged
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
      wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  // Sticky error across the APB transfers of one AXI write, and sticky protocol error
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_acc     <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      err_acc     <= pop ? 1'b0 : accept ? err_acc | wr_err_i : err_acc;
      proto_err_o <= proto_err_o | (wr_done_i && count == '0);
    end
  end
  // B slot state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_next;
  end
  // Loading a new beat wins over draining the current one
  always_comb begin
    state_next = state;
    state_next = pop ? VALID : master_ready_i ? IDLE : state;
  end
  // B payload is captured only on a completing write, so it holds while stalled
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      master_id_o   <= '0;
      master_user_o <= '0;
      master_resp_o <= 2'b00;
    end else if (pop) begin
      {master_id_o, master_user_o} <= head;
      master_resp_o                <= {err_acc | wr_err_i, 1'b0};
    end
  end
endmodule

// File: tb/tb_axi_b_resp_gen.sv
// tb_axi_b_resp_gen: scoreboard bench with a queue-based reference model
module tb_axi_b_resp_gen;
  localparam int IW = 4, UW = 1, D = 4, CW = $clog2(D + 1);
  logic clk_i = 0, rst_ni = 0;
  logic aw_push_i = 0, wr_done_i = 0, wr_err_i = 0, wr_last_i = 0, master_ready_i = 0;
  logic [IW-1:0] aw_id_i = 0, master_id_o;
  logic [UW-1:0] aw_user_i = 0, master_user_o;
  logic aw_ready_o, done_ready_o, master_valid_o, proto_err_o;
  logic [1:0] master_resp_o;
  logic [CW-1:0] outstanding_o;
  int n_tests = 0, n_fail = 0;
  logic [IW+UW-1:0] tag_q[$];
  logic [IW+UW+1:0] exp_q[$];
  bit err_acc = 0, b_pend = 0, proto = 0;

  axi_b_resp_gen #(.ID_WIDTH(IW), .USER_WIDTH(UW), .BUFFER_DEPTH(D)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .aw_push_i(aw_push_i), .aw_id_i(aw_id_i),
    .aw_user_i(aw_user_i), .aw_ready_o(aw_ready_o), .wr_done_i(wr_done_i),
    .wr_err_i(wr_err_i), .wr_last_i(wr_last_i), .done_ready_o(done_ready_o),
    .master_valid_o(master_valid_o), .master_resp_o(master_resp_o),
    .master_id_o(master_id_o), .master_user_o(master_user_o),
    .master_ready_i(master_ready_i), .outstanding_o(outstanding_o),
    .proto_err_o(proto_err_o));

  always #5 clk_i = ~clk_i;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic cyc(input bit push, input int id, input int u, input bit done,
                     input bit err, input bit last, input bit ready);
    bit exp_dr, acc;
    logic [IW+UW-1:0] t;
    @(negedge clk_i);
    aw_push_i = push; aw_id_i = IW'(id); aw_user_i = UW'(u);
    wr_done_i = done; wr_err_i = err; wr_last_i = last; master_ready_i = ready;
    #1;
    exp_dr = tag_q.size() != 0 && (!last || !b_pend || ready);
    chk("aw_ready", 32'(aw_ready_o), 32'(tag_q.size() < D));
    chk("done_ready", 32'(done_ready_o), 32'(exp_dr));
    chk("outstanding", 32'(outstanding_o), 32'(tag_q.size()));
    chk("valid", 32'(master_valid_o), 32'(b_pend));
    chk("proto_err", 32'(proto_err_o), 32'(proto));
    acc = done && exp_dr;
    if (done && tag_q.size() == 0) proto = 1;
    b_pend = (acc && last) ? 1'b1 : (b_pend && ready) ? 1'b0 : b_pend;
    if (push && tag_q.size() < D) begin
      if (acc && last) begin
        t = tag_q.pop_front();
        exp_q.push_back({t, (err_acc | err) ? 2'b10 : 2'b00});
        err_acc = 0;
        tag_q.push_back({IW'(id), UW'(u)});
      end else begin
        if (acc) err_acc |= err;
        tag_q.push_back({IW'(id), UW'(u)});
      end
    end else if (acc && last) begin
      t = tag_q.pop_front();
      exp_q.push_back({t, (err_acc | err) ? 2'b10 : 2'b00});
      err_acc = 0;
    end else if (acc) err_acc |= err;
  endtask

  task automatic idle(input bit ready, input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, ready);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 0; aw_push_i = 0; wr_done_i = 0; wr_err_i = 0; wr_last_i = 0; master_ready_i = 0;
    @(negedge clk_i);
    rst_ni = 1;
    tag_q.delete(); exp_q.delete(); err_acc = 0; b_pend = 0; proto = 0;
    #1;
    chk("rst aw_ready", 32'(aw_ready_o), 1);
    chk("rst done_ready", 32'(done_ready_o), 0);
    chk("rst valid", 32'(master_valid_o), 0);
    chk("rst resp", 32'(master_resp_o), 0);
    chk("rst id", 32'(master_id_o), 0);
    chk("rst user", 32'(master_user_o), 0);
    chk("rst outstanding", 32'(outstanding_o), 0);
    chk("rst proto_err", 32'(proto_err_o), 0);
  endtask

  task automatic single_write();
    cyc(1, 3, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    idle(0, 3);
    idle(1, 1);
    idle(0, 1);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks the payload holds while stalled
  initial begin
    logic [IW+UW+1:0] got, prev, e;
    bit prev_stall = 0;
    forever begin
      @(negedge clk_i);
      #2;
      got = {master_id_o, master_user_o, master_resp_o};
      if (prev_stall && master_valid_o) chk("b_hold", 32'(got), 32'(prev));
      if (master_valid_o && master_ready_i && rst_ni) begin
        if (exp_q.size() == 0) chk("b_unexpected", 32'(got), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("b_beat", 32'(got), 32'(e));
        end
      end
      prev_stall = master_valid_o && !master_ready_i;
      prev = got;
    end
  end

  initial begin
    do_reset();
    single_write();
    cyc(1, 5, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1, 1);
    cyc(1, 6, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1, 1);
    idle(1, 2);
    cyc(1, 7, 0, 0, 0, 0, 0);
    cyc(1, 8, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    idle(0, 1);
    cyc(0, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 1, 1);
    idle(1, 2);
    for (int i = 1; i <= 4; i++) cyc(1, i, i % 2, 0, 0, 0, 1);
    cyc(1, 9, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, i == 2, 1, 1);
    idle(1, 2);
    cyc(0, 0, 0, 1, 0, 1, 1);
    idle(1, 1);
    cyc(1, 10, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1, 1);
    idle(1, 2);
    cyc(1, 11, 0, 0, 0, 0, 0);
    cyc(1, 12, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 0);
    idle(0, 1);
    do_reset();
    single_write();
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 99) < 45, $urandom_range(0, 15), $urandom_range(0, 1),
          $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 65);
    idle(1, 3);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_b_resp_gen.md
# axi_b_resp_gen

Write-response generator for the APB side of the AXI-to-APB bridge. It records the ID/USER of every accepted AW transaction in an in-order tag FIFO, accumulates APB error status across the APB transfers of each AXI write, and issues one AXI B beat per completed write. It is the producer that feeds the B-channel buffer toward the AXI master.

## Interface
- ID_WIDTH, 4: AXI ID width.
- USER_WIDTH, 1: AXI USER width.
- BUFFER_DEPTH, 4: maximum outstanding AW tags (≥1, need not be a power of 2).

Clocking and reset: one clock, `clk_i`; reset `rst_ni` is synchronous and active-low.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- aw_push_i  in  1  AW accepted; store tag this cycle
- aw_id_i  in  ID_WIDTH  AW ID
- aw_user_i  in  USER_WIDTH  AW USER
- aw_ready_o  out  1  tag FIFO can accept (count < BUFFER_DEPTH)
- wr_done_i  in  1  one APB write transfer completed
- wr_err_i  in  1  that transfer returned PSLVERR
- wr_last_i  in  1  that transfer was the last of the AXI write
- done_ready_o  out  1  completion accepted this cycle
- master_valid_o  out  1  B valid
- master_resp_o  out  2  B resp (2'b00 OKAY, 2'b10 SLVERR)
- master_id_o  out  ID_WIDTH  B ID
- master_user_o  out  USER_WIDTH  B USER
- master_ready_i  in  1  B ready
- outstanding_o  out  $clog2(BUFFER_DEPTH+1)  tags currently stored
- proto_err_o  out  1  sticky: completion seen with no outstanding tag

## Operation
- Tag FIFO: circular, BUFFER_DEPTH entries of {id,user}; rd/wr pointers wrap at BUFFER_DEPTH-1→0; count register.
- Push: aw_push_i && aw_ready_o writes a tag. aw_ready_o depends only on the registered count. A same-cycle pop does not free a slot for that cycle's push. A push while full is ignored and the count is unchanged.
- Error accumulator `err_acc`, 1 bit, sticky.
  - Accepted non-last done: err_acc |= wr_err_i.
  - Accepted last done: cleared.
- B slot, two states.
  - IDLE (master_valid_o=0).
  - VALID (master_valid_o=1; id/user/resp held stable).
  - VALID→IDLE on master_ready_i.
  - IDLE or VALID→VALID on an accepted last done. This takes priority over the handshake drain in the same cycle.
- done_ready_o = (count≠0) && (!wr_last_i || !master_valid_o || master_ready_i). It is combinational on wr_last_i and the B handshake.
- Accepted last done:
  - pop the head tag;
  - load it into the B slot;
  - master_resp_o = (err_acc | wr_err_i) ? 2'b10 : 2'b00.
- Non-last done never produces B.
- wr_done_i while count==0: not accepted, no B, no FIFO or accumulator change; proto_err_o set to 1 until reset.
- Simultaneous push and pop: count unchanged, both pointers advance.

## Timing
- Reset values:
  - aw_ready_o=1, done_ready_o=0, master_valid_o=0;
  - master_resp_o/id/user=0, outstanding_o=0, proto_err_o=0;
  - FIFO empty, err_acc=0.
- Reset mid-operation discards any pending B beat, all tags and err_acc in the same cycle.
- Latency:
  - accepted last done at cycle N → master_valid_o=1 at N+1;
  - push at N → count visible at N+1 → earliest done at N+1 → B at N+2.
- Back-to-back: with master_ready_i=1 continuously, one B beat per cycle is sustained.
- B outputs must not change while master_valid_o=1 && !master_ready_i.
- outstanding_o is the registered count and updates one cycle after push/pop.

## Test plan
- Single write: push id=3, user=1; next cycle done+last, err=0 → B id=3, user=1, resp=00 valid one cycle later, held 3 cycles with ready=0, dropped the cycle after ready=1.
- Error burst: push id=5; dones with err=0,1,0(last) → one B id=5 resp=10. A following write id=6 with all err=0 → resp=00 (accumulator cleared).
- Backpressure: two writes outstanding, master_ready_i=0 → second last-done sees done_ready_o=0 until the first B handshakes. With ready=1 in the same cycle it is accepted immediately and B id changes on consecutive cycles.
- Fill/order: push ids 1,2,3,4 (depth 4) → aw_ready_o=0, outstanding_o=4. A push of id 9 is ignored. Four completions → B ids 1,2,3,4 in order, outstanding_o returns to 0.
- Protocol error: done+last with FIFO empty → done_ready_o=0, no B, proto_err_o=1 and stays 1 through later normal writes.
- Reset mid-operation: 2 tags stored, B pending with ready=0, rst_ni=0 one cycle → all outputs at reset values next cycle. A subsequent write behaves as in scenario 1.
